// File: rtl/arm_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : arm_mem_pkg                                                     |
// | Brief    : Shared types and constants for the SRAM-backed memory stage.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package arm_mem_pkg;

  localparam int unsigned MEM_BASE_DEFAULT = 1024;
  localparam int unsigned SRAM_DQ_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Select the 16-bit half of a 32-bit word placed on the SRAM bus.
  function automatic logic [SRAM_DQ_W-1:0] half_sel(input logic hi, input logic [31:0] word);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_controller                                                 |
// | Brief    : 32-bit data-memory stage over a 16-bit async SRAM, two halves.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned MEM_BASE    = MEM_BASE_DEFAULT,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            address,
  input  logic [31:0]            data,
  output logic [31:0]            mem_result,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DQ_W-1:0]   sram_dq_out,
  input  logic [SRAM_DQ_W-1:0]   sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned      WORD_W   = SRAM_ADDR_W - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  mem_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            mem_result_q, mem_result_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DQ_W-1:0]   dq_out_q, dq_out_d;
  logic                   oe_q, oe_d;
  logic                   we_n_q, we_n_d;

  logic [31:0]            w_offset;
  logic [WORD_W-1:0]      w_word;
  logic                   w_req;
  logic                   w_last;
  logic                   w_half;

  assign w_offset = address - 32'(MEM_BASE);
  assign w_word   = WORD_W'(w_offset >> 2);
  assign w_req    = mem_read | mem_write;
  assign w_last   = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      word_q       <= '0;
      wdata_q      <= '0;
      mem_result_q <= '0;
      sram_addr_q  <= '0;
      dq_out_q     <= '0;
      oe_q         <= 1'b0;
      we_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      mem_result_q <= mem_result_d;
      sram_addr_q  <= sram_addr_d;
      dq_out_q     <= dq_out_d;
      oe_q         <= oe_d;
      we_n_q       <= we_n_d;
    end
  end

  // The operation is latched at acceptance so a request dropped mid-access still completes.
  always_comb begin : p_next
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    word_d       = word_q;
    wdata_d      = wdata_q;
    mem_result_d = mem_result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          state_d = ST_LO;
          cnt_d   = '0;
          wr_d    = mem_write;
          rd_d    = mem_read & ~mem_write;
          word_d  = w_word;
          wdata_d = data;
        end
      end
      ST_LO: begin
        if (w_last) begin
          if (rd_q) mem_result_d[15:0] = sram_dq_in;
          state_d = ST_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (w_last) begin
          if (rd_q) mem_result_d[31:16] = sram_dq_in;
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the state they belong to;
  // we_n releases one cycle before the half ends, while address and data are still held.
  always_comb begin : p_out
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    oe_d        = 1'b0;
    we_n_d      = 1'b1;
    w_half      = (state_d == ST_HI);
    if ((state_d == ST_LO) || (state_d == ST_HI)) begin
      sram_addr_d = {word_d, w_half};
      if (wr_d) begin
        dq_out_d = half_sel(w_half, wdata_d);
        oe_d     = 1'b1;
        we_n_d   = (cnt_d == CNT_LAST);
      end
    end
  end

  assign ready       = (state_q == ST_DONE) | ((state_q == ST_IDLE) & ~w_req);
  assign mem_result  = mem_result_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule
`default_nettype wire
